// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues word-aligned fetches and buffers returned instructions for decode.
// Optional macro FETCH_PERF_EN adds the perf_fetched / perf_flushes counters (ports exist either way).
`ifndef WORD
`define WORD 32
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module fetch_unit #(
    parameter logic [`WORD-1:0] RESET_PC   = '0,
    parameter int               FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [`WORD-1:0]      imem_addr,
    input  logic [`INSTR_LEN-1:0] imem_instr,
    output logic [`INSTR_LEN-1:0] if_instr,
    output logic [`WORD-1:0]      if_pc,
    output logic                  if_valid,
    input  logic                  if_ready,
    input  logic                  redirect,
    input  logic [`WORD-1:0]      redirect_pc,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_flushes
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    logic [`WORD-1:0]      pc_q;
    logic [`WORD-1:0]      inflight_pc_q;
    logic                  inflight_q;
    logic [`INSTR_LEN-1:0] instr_mem_q [FIFO_DEPTH];
    logic [`WORD-1:0]      pc_mem_q    [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  pop_req;
    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [CW:0]           occupied;
    logic [CW:0]           limit;
    logic [`WORD-1:0]      redirect_target;
    logic                  unused_redirect_bits;

    assign redirect_target      = {redirect_pc[`WORD-1:2], 2'b00};
    assign unused_redirect_bits = &{1'b0, redirect_pc[1:0]};

    assign imem_addr = pc_q;
    assign if_valid  = (count_q != '0);
    assign if_instr  = instr_mem_q[rd_ptr_q];
    assign if_pc     = pc_mem_q[rd_ptr_q];

    // The in-flight response already owns a slot, so it is counted against the depth before issuing.
    always_comb begin
        pop_req  = if_valid & if_ready;
        pop      = pop_req & ~redirect;
        push     = inflight_q & ~redirect;
        occupied = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        limit    = DEPTH_C + {{CW{1'b0}}, pop_req};
        issue    = ~redirect & (occupied < limit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else if (redirect) begin
            pc_q       <= redirect_target;
            inflight_q <= 1'b0;
        end else if (issue) begin
            pc_q          <= pc_q + `WORD'(4);
            inflight_q    <= 1'b1;
            inflight_pc_q <= pc_q;
        end else begin
            inflight_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else if (redirect) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                instr_mem_q[wr_ptr_q] <= imem_instr;
                pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
                wr_ptr_q              <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q;
    logic [31:0] flushes_q;

    // A pop that coincides with a redirect is discarded by decode, so only clean pops count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            flushes_q <= '0;
        end else begin
            if (pop) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (redirect) begin
                flushes_q <= flushes_q + 32'd1;
            end
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushes = flushes_q;
`else
    assign perf_fetched = '0;
    assign perf_flushes = '0;
`endif

endmodule
